// File: rtl/drum_pkg.sv
// drum_pkg: FSM state encoding, grade codes and default geometry shared by drum_pad_judge
package drum_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam logic [1:0] GRADE_NONE    = 2'b00;
  localparam logic [1:0] GRADE_GOOD    = 2'b01;
  localparam logic [1:0] GRADE_PERFECT = 2'b10;
  localparam int POS_W_DEF = 10;
  localparam int HIT_Y_DEF = 384;
endpackage

// File: rtl/pad_debounce.sv
// pad_debounce: 2-flop synchroniser, debounce counter, accepted level and registered press pulse for one pad
//   clk     : system clock
//   reset   : synchronous active-high reset
//   i_pad   : raw asynchronous pad level, 1 = pressed
//   o_press : 1-cycle pulse per accepted 0->1 transition of the debounced level
module pad_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pad,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic r_s0, r_s1, r_stable, r_stable_d, r_press;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s0       <= i_pad;
      r_s1       <= r_s0;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      if (r_s1 == r_stable) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_stable <= r_s1;
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/drum_pad_judge.sv
// drum_pad_judge: debounces the drum pads and judges each press against its lane's falling note
//   clk, reset : system clock, synchronous active-high reset
//   enable     : game running
//   boton      : raw pad inputs, 1 = pressed
//   nota_y     : lane i note Y at [i*POS_W +: POS_W]
//   nota_val   : lane i has a note on screen
//   hit_mask   : 1-cycle pulse per lane judged hit
//   miss_mask  : 1-cycle pulse per lane judged miss
//   combo      : consecutive hits, saturating at 255
//   perdio     : game over, held until reset
//   grade      : grade of the lowest-index hit this cycle
//   Optional grading is built only when DRUM_PAD_GRADE_EN is defined; otherwise grade is tied to 0.
module drum_pad_judge
  import drum_pkg::*;
#(
  parameter int N_LANES    = 5,
  parameter int POS_W      = POS_W_DEF,
  parameter int HIT_Y      = HIT_Y_DEF,
  parameter int WINDOW     = 16,
  parameter int DEB_CYCLES = 250000,
  parameter int MAX_MISS   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_LANES-1:0]       boton,
  input  logic [N_LANES*POS_W-1:0] nota_y,
  input  logic [N_LANES-1:0]       nota_val,
  output logic [N_LANES-1:0]       hit_mask,
  output logic [N_LANES-1:0]       miss_mask,
  output logic [7:0]               combo,
  output logic                     perdio,
  output logic [1:0]               grade
);
  localparam int MW = $clog2(MAX_MISS + 1);
  localparam logic [POS_W:0] Y_HIT = (POS_W+1)'(HIT_Y);
  localparam logic [POS_W:0] Y_LO  = (POS_W+1)'(HIT_Y - WINDOW);
  localparam logic [POS_W:0] Y_HI  = (POS_W+1)'(HIT_Y + WINDOW);
  localparam logic [POS_W:0] WIN   = (POS_W+1)'(WINDOW);
  localparam logic [MW-1:0] MISS_END = MW'(MAX_MISS);
  state_t r_state, w_state_nx;
  logic [N_LANES-1:0] w_press, w_hit, w_miss, w_pass, w_rearm, r_armed, r_hit, r_miss;
  logic [POS_W:0] w_y [N_LANES];
  logic [POS_W:0] w_d [N_LANES];
  logic [7:0] r_combo;
  logic [MW-1:0] r_miss_run, w_miss_run_nx;
  logic r_perdio, w_play, w_any_hit, w_any_miss;
  assign w_play = (r_state == PLAY);
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    pad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .i_pad  (boton[i]),
      .o_press(w_press[i])
    );
    // one extra bit so the distance and the window bounds never wrap
    assign w_y[i]     = {1'b0, nota_y[i*POS_W +: POS_W]};
    assign w_d[i]     = (w_y[i] >= Y_HIT) ? w_y[i] - Y_HIT : Y_HIT - w_y[i];
    assign w_hit[i]   = w_play & w_press[i] & nota_val[i] & (w_d[i] <= WIN) & r_armed[i];
    assign w_pass[i]  = nota_val[i] & r_armed[i] & (w_y[i] > Y_HI);
    // a press is always judged, so a pass-through miss only counts when the lane is not pressed
    assign w_miss[i]  = w_play & (w_press[i] ? ~w_hit[i] : w_pass[i]);
    assign w_rearm[i] = ~nota_val[i] | (w_y[i] < Y_LO);
  end
  assign w_any_hit     = |w_hit;
  assign w_any_miss    = |w_miss;
  assign w_miss_run_nx = w_any_miss ? r_miss_run + MW'(1) : w_any_hit ? '0 : r_miss_run;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = enable ? PLAY : IDLE;
      PLAY:    w_state_nx = (w_miss_run_nx == MISS_END) ? OVER : enable ? PLAY : IDLE;
      default: w_state_nx = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_armed    <= '1;
      r_hit      <= '0;
      r_miss     <= '0;
      r_combo    <= '0;
      r_miss_run <= '0;
      r_perdio   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      // disarm on a judged hit or on a note sliding past the band; a new note entering re-arms
      r_armed    <= (r_armed & ~(w_hit | ({N_LANES{w_play}} & w_pass))) | w_rearm;
      r_hit      <= w_hit;
      r_miss     <= w_miss;
      r_combo    <= w_any_miss ? '0 : (w_any_hit && r_combo != 8'hFF) ? r_combo + 8'd1 : r_combo;
      r_miss_run <= w_miss_run_nx;
      r_perdio   <= r_perdio | (w_miss_run_nx == MISS_END);
    end
  end
  assign hit_mask  = r_hit;
  assign miss_mask = r_miss;
  assign combo     = r_combo;
  assign perdio    = r_perdio;
`ifdef DRUM_PAD_GRADE_EN
  localparam logic [POS_W:0] WIN_P = (POS_W+1)'(WINDOW / 4);
  logic [1:0] r_grade, w_grade;
  always_comb begin
    w_grade = GRADE_NONE;
    for (int k = N_LANES - 1; k >= 0; k--)
      if (w_hit[k]) w_grade = (w_d[k] <= WIN_P) ? GRADE_PERFECT : GRADE_GOOD;
  end
  always_ff @(posedge clk) r_grade <= reset ? GRADE_NONE : w_grade;
  assign grade = r_grade;
`else
  assign grade = GRADE_NONE;
`endif
endmodule
